// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// stream_demux_pkg : shared constants and slot-state type for stream_demux_1_4
// Revision: 1.0
// ============================================================================
package stream_demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// demux_slot : one-entry output slot with data register and transfer counter
// Revision: 1.0
// ============================================================================
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);

  slot_state_t       r_state;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;
  logic              w_rd;

  assign w_rd = (r_state == FULL) & out_ready;

  // A write always wins over a drain, so FULL+drain+write stays FULL with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      if (wr_en) begin
        r_state <= FULL;
        r_data  <= wr_data;
      end else if (w_rd) begin
        r_state <= EMPTY;
      end
      if (w_rd) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_count = r_count;

endmodule
`default_nettype wire

// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// stream_demux_1_4 : valid/ready demux of one input stream onto four slots
// Revision: 1.0
// ============================================================================
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0]  out_count
);

  logic [NUM_CH-1:0] w_wr_en;

  // Only the addressed slot gates acceptance; stalls elsewhere never block.
  assign in_ready = (!out_valid[in_sel] | out_ready[in_sel]) & !rst;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      assign w_wr_en[k] = in_valid & in_ready & (in_sel == SEL_W'(k));

      demux_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_wr_en[k]),
        .wr_data   (in_data),
        .out_ready (out_ready[k]),
        .out_valid (out_valid[k]),
        .out_data  (out_data[k*DATA_W +: DATA_W]),
        .out_count (out_count[k*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// tb_stream_demux_1_4 : directed and random scoreboard bench for stream_demux_1_4
// Revision: 1.0
// ============================================================================
module tb_stream_demux_1_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [31:0] out_count;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  sbq [4][$];
  logic [7:0]  mcnt [4];
  logic        last_acc;

  always #5 clk = ~clk;

  stream_demux_1_4 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  function automatic logic [7:0] dat(input int k);
    return out_data[k*8 +: 8];
  endfunction

  function automatic logic [7:0] cnt(input int k);
    return out_count[k*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Negedge scoreboard: handshakes seen here complete on the following rising edge.
  task automatic score();
    if (rst) begin
      chk("rst_valid", {28'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_count", out_count, 32'd0);
      chk("rst_data", out_data, 32'd0);
      for (int k = 0; k < 4; k++) begin
        sbq[k].delete();
        mcnt[k] = 8'd0;
      end
      last_acc = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("sb_valid", {31'd0, out_valid[k]}, {31'd0, sbq[k].size() != 0});
        chk("sb_count", {24'd0, cnt(k)}, {24'd0, mcnt[k]});
        if (out_valid[k] && out_ready[k]) begin
          if (sbq[k].size() != 0) begin
            chk("sb_data", {24'd0, dat(k)}, {24'd0, sbq[k].pop_front()});
          end
          mcnt[k] = mcnt[k] + 8'd1;
        end
      end
      chk("sb_in_ready", {31'd0, in_ready},
          {31'd0, !out_valid[in_sel] | out_ready[in_sel]});
      last_acc = in_valid & in_ready;
      if (last_acc) sbq[in_sel].push_back(in_data);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    score();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 8'd0;
    out_ready = 4'd0;
    last_acc  = 1'b0;
    for (int k = 0; k < 4; k++) mcnt[k] = 8'd0;
    tick();
    tick();
    rst = 1'b0;

    // Single write to channel 2, one-cycle latency
    in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
    #1 chk("a_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("a_valid", {28'd0, out_valid}, 32'h4);
    chk("a_data", {24'd0, dat(2)}, 32'hA5);
    tick();
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("a_drained", {28'd0, out_valid}, 32'h0);
    chk("a_count2", {24'd0, cnt(2)}, 32'd1);

    // Stalled channel 1 blocks only itself
    in_sel = 2'd1; in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_data = 8'h77;
    #1 chk("b_stall_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("b_hold_data", {24'd0, dat(1)}, 32'h3C);
    chk("b_hold_valid", {31'd0, out_valid[1]}, 32'd1);
    in_sel = 2'd3; in_data = 8'h5A;
    #1 chk("b_other_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b_ch3_data", {24'd0, dat(3)}, 32'h5A);
    chk("b_valid", {28'd0, out_valid}, 32'hA);
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    chk("b_drained", {28'd0, out_valid}, 32'h0);

    // Back-to-back writes on a draining channel 0
    out_ready = 4'b0001; in_sel = 2'd0; in_valid = 1'b1; in_data = 8'h11;
    tick();
    chk("c_v1", {31'd0, out_valid[0]}, 32'd1);
    chk("c_d1", {24'd0, dat(0)}, 32'h11);
    in_data = 8'h22;
    tick();
    chk("c_v2", {31'd0, out_valid[0]}, 32'd1);
    chk("c_d2", {24'd0, dat(0)}, 32'h22);
    in_data = 8'h33;
    tick();
    chk("c_v3", {31'd0, out_valid[0]}, 32'd1);
    chk("c_d3", {24'd0, dat(0)}, 32'h33);
    in_valid = 1'b0;
    tick();
    chk("c_empty", {31'd0, out_valid[0]}, 32'd0);
    chk("c_data_kept", {24'd0, dat(0)}, 32'h33);
    chk("c_count0", {24'd0, cnt(0)}, 32'd3);
    out_ready = 4'b0000;

    // Fill all four slots, then reset asynchronously mid-cycle
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k); in_data = 8'hC0 + 8'(k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("d_all_full", {28'd0, out_valid}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("d_async_valid", {28'd0, out_valid}, 32'h0);
    chk("d_async_count", out_count, 32'h0);
    chk("d_async_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    in_sel = 2'd0; in_data = 8'h99; in_valid = 1'b1;
    #1 chk("d_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("d_first_valid", {28'd0, out_valid}, 32'h1);
    chk("d_first_data", {24'd0, dat(0)}, 32'h99);

    // 256 transfers on channel 3 wrap its counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 4'b1000; in_sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      tick();
    end
    chk("e_count_ff", {24'd0, cnt(3)}, 32'hFF);
    in_valid = 1'b0;
    tick();
    chk("e_count_wrap", {24'd0, cnt(3)}, 32'h0);
    chk("e_others_zero", {8'd0, out_count[23:0]}, 32'h0);
    chk("e_empty", {28'd0, out_valid}, 32'h0);

    // Random traffic; a stalled word is held until accepted
    for (int i = 0; i < 10000; i++) begin
      out_ready = 4'($urandom);
      if (!in_valid || last_acc) begin
        in_valid = 1'($urandom);
        in_sel   = 2'($urandom);
        in_data  = 8'($urandom);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    tick();
    tick();
    chk("f_drained", {28'd0, out_valid}, 32'h0);
    chk("f_sb_empty", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 Parameter DATA_W, default 8: width of the payload on the input and on each output channel.
REQ-002 Parameter CNT_W, default 8: width of each per-channel delivered-transfer counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: the upstream word is valid.
REQ-007 Port in_ready, output, 1: the block can accept the upstream word this cycle.
REQ-008 Port in_data, input, DATA_W: the upstream payload.
REQ-009 Port in_sel, input, 2: destination channel 0..3; must be stable while in_valid is high.
REQ-010 Port out_valid, output, 4: bit k means channel k holds a word.
REQ-011 Port out_ready, input, 4: bit k means the channel k consumer accepts the word.
REQ-012 Port out_data, output, 4*DATA_W: channel k payload in bits [k*DATA_W +: DATA_W].
REQ-013 Port out_count, output, 4*CNT_W: channel k delivered-transfer count in bits [k*CNT_W +: CNT_W].

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high at a rising clk edge.
REQ-015 An output transfer on channel k SHALL occur when out_valid[k] and out_ready[k] are both high at a rising clk edge.
REQ-016 Each channel SHALL be a one-entry slot with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-017 in_ready SHALL equal (!out_valid[in_sel] | out_ready[in_sel]) & !rst, combinationally.
REQ-018 in_ready SHALL NOT depend on in_valid.
REQ-019 An input transfer SHALL load in_data into slot in_sel and set out_valid[in_sel] on the next edge; latency is exactly 1 cycle.
REQ-020 Slot in_sel SHALL take the new data on that edge whether it was EMPTY, or FULL and draining in the same cycle.
REQ-021 A slot in state FULL with an output transfer and no input transfer to it SHALL go to EMPTY; out_data[k] SHALL keep its last value.
REQ-022 A slot in state FULL with both an output and an input transfer on the same edge SHALL stay FULL and hold the new data, with no bubble.
REQ-023 A slot in state FULL without out_ready[k] SHALL hold its data and valid indefinitely; in_ready for that channel SHALL be low.
REQ-024 A stalled channel SHALL NOT block input transfers addressed to the other channels.
REQ-025 Channels not addressed by in_sel SHALL be unaffected by input traffic.
REQ-026 out_count[k] SHALL increment by 1 on every output transfer on channel k.
REQ-027 out_count[k] SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 Output transfers on several channels in the same cycle SHALL each be counted independently.

Reset
REQ-029 While rst is high: out_valid=0, out_data=0, out_count=0, in_ready=0.
REQ-030 Reset asserted mid-transfer SHALL discard all held words with no partial state retained.
REQ-031 The first input transfer SHALL be possible on the first rising clk edge after rst deasserts.

Structure
REQ-032 Package stream_demux_pkg SHALL hold NUM_CH=4, SEL_W=2 and the slot-state typedef {EMPTY, FULL}.
REQ-033 Sub-module demux_slot SHALL implement one slot (data register, state, counter) and be instantiated NUM_CH times.
REQ-034 The top level SHALL contain only the in_ready mux, the write-enable decode and the port flattening.

Verification
REQ-035 Reset, then in_sel=2, in_data=8'hA5, in_valid=1 for one cycle, out_ready=4'b0000 -> next cycle out_valid=4'b0100, channel 2 data=8'hA5, other channels invalid.
REQ-036 Channel 1 FULL with out_ready[1]=0, in_sel=1 -> in_ready=0 and data held; then in_sel=3 -> in_ready=1 and channel 3 loads.
REQ-037 Channel 0 FULL with out_ready[0]=1 and a back-to-back write of 8'h11, 8'h22, 8'h33 to channel 0 -> out_valid[0] stays 1 throughout, data sequence 11/22/33, out_count[0]=3.
REQ-038 256 output transfers on channel 3 with CNT_W=8 -> out_count[3] returns to 0; the other counters stay 0.
REQ-039 rst pulsed while all four slots are FULL -> out_valid=0, out_count=0 immediately, in_ready=0 during reset, and in_ready=1 on the first cycle after release.
REQ-040 Random in_valid/out_ready/in_sel for 10k cycles against a scoreboard -> per-channel order preserved, no loss or duplication, counts match.
